// File: rtl/wave_counter_pkg.sv
// Shared wavetable constants and width helpers used by the oscillators and
// the sample-address counter.
package wave_pkg;

  localparam real SAMPLE_FREQ_HZ = 44100.0;
  localparam real NOTE_FREQ_HZ   = 440.0;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DOWN = 2'd2
  } step_e;

  function automatic int wave_depth(input real sample_hz, input real note_hz);
    return $rtoi(sample_hz / note_hz);
  endfunction

  // Address width for n entries, never below one bit.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEFAULT_DEPTH = wave_depth(SAMPLE_FREQ_HZ, NOTE_FREQ_HZ);

endpackage

// File: rtl/wave_counter_if.sv
// Step request / sample-address bundle between an oscillator and its counter.
interface wave_counter_if #(
  parameter int width_p = 1
) ();

  logic               up_i;
  logic               down_i;
  logic [width_p-1:0] count_o;

  modport master (output up_i, output down_i, input  count_o);
  modport slave  (input  up_i, input  down_i, output count_o);

endinterface

// File: rtl/wave_counter.sv
// Modulo up/down counter sweeping a wavetable of max_val_p+1 entries;
// count_o feeds a synchronous ROM address directly from the register.
module wave_counter
  import wave_pkg::*;
#(
  parameter  int max_val_p = DEFAULT_DEPTH - 1,
  localparam int width_lp  = clog2_min1(max_val_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                up_i,
  input  logic                down_i,
  output logic [width_lp-1:0] count_o
);

  if (max_val_p < 1) begin : g_bad_max
    $error("wave_counter: max_val_p must be at least 1");
  end

  localparam logic [width_lp-1:0] MaxLp = width_lp'(max_val_p);
  localparam logic [width_lp-1:0] OneLp = width_lp'(1);

  logic [width_lp-1:0] count_q;
  logic [width_lp-1:0] count_d;
  step_e               step;

  // Wrap compares against max_val_p, not the all-ones code, so the period
  // is exactly max_val_p+1 even when the table is not a power of two.
  always_comb begin
    step    = STEP_HOLD;
    count_d = count_q;
    if (up_i && !down_i) begin
      step = STEP_UP;
    end else if (down_i && !up_i) begin
      step = STEP_DOWN;
    end
    case (step)
      STEP_UP:   count_d = (count_q == MaxLp) ? '0 : count_q + OneLp;
      STEP_DOWN: count_d = (count_q == '0) ? MaxLp : count_q - OneLp;
      default:   count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

  a_in_range: assert property (@(posedge clk_i) count_q <= MaxLp);

  a_step_up: assert property (@(posedge clk_i) disable iff (reset_i)
    (up_i && !down_i) |=>
      count_q == (($past(count_q) == MaxLp) ? '0 : $past(count_q) + OneLp));

  a_step_down: assert property (@(posedge clk_i) disable iff (reset_i)
    (down_i && !up_i) |=>
      count_q == (($past(count_q) == '0) ? MaxLp : $past(count_q) - OneLp));

  a_hold: assert property (@(posedge clk_i) disable iff (reset_i)
    (up_i == down_i) |=> count_q == $past(count_q));

endmodule

// File: tb/tb_wave_counter.sv
// Directed and model-checked stimulus for wave_counter at depths 100, 8 and 2.
module tb_wave_counter;
  import wave_pkg::*;

  localparam int W99 = clog2_min1(100);
  localparam int W7  = clog2_min1(8);
  localparam int W1  = clog2_min1(2);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  wave_counter_if #(.width_p(W99)) if99 ();
  wave_counter_if #(.width_p(W7))  if7  ();
  wave_counter_if #(.width_p(W1))  if1  ();

  wave_counter #(.max_val_p(99)) u_dut99 (
    .clk_i(clk), .reset_i(rst), .up_i(if99.up_i), .down_i(if99.down_i), .count_o(if99.count_o)
  );
  wave_counter #(.max_val_p(7)) u_dut7 (
    .clk_i(clk), .reset_i(rst), .up_i(if7.up_i), .down_i(if7.down_i), .count_o(if7.count_o)
  );
  wave_counter #(.max_val_p(1)) u_dut1 (
    .clk_i(clk), .reset_i(rst), .up_i(if1.up_i), .down_i(if1.down_i), .count_o(if1.count_o)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_next(input int cur, input bit up, input bit dn, input int mx);
    if (up && !dn) return (cur == mx) ? 0 : cur + 1;
    if (dn && !up) return (cur == 0) ? mx : cur - 1;
    return cur;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int m7;
    int m1;
    bit u;
    bit d;
    {if99.up_i, if99.down_i} = 2'b00;
    {if7.up_i,  if7.down_i}  = 2'b00;
    {if1.up_i,  if1.down_i}  = 2'b00;

    // Reset with random requests on every instance
    for (int i = 0; i < 4; i++) begin
      {if99.up_i, if99.down_i} = 2'($urandom_range(0, 3));
      {if7.up_i,  if7.down_i}  = 2'($urandom_range(0, 3));
      {if1.up_i,  if1.down_i}  = 2'($urandom_range(0, 3));
      step();
      check("reset99", int'(if99.count_o), 0);
      check("reset7",  int'(if7.count_o),  0);
      check("reset1",  int'(if1.count_o),  0);
    end
    {if99.up_i, if99.down_i} = 2'b00;
    {if7.up_i,  if7.down_i}  = 2'b00;
    {if1.up_i,  if1.down_i}  = 2'b00;
    rst = 1'b0;

    // Up sweep: 0..99, 0..99, 0..49
    check("up99_start", int'(if99.count_o), 0);
    if99.up_i = 1'b1;
    for (int k = 1; k < 250; k++) begin
      step();
      check("up99", int'(if99.count_o), k % 100);
    end
    if99.up_i = 1'b0;

    // Down sweep from reset: 99, 98, ..., 0, 99
    do_reset();
    if99.down_i = 1'b1;
    for (int k = 1; k <= 101; k++) begin
      step();
      check("down99", int'(if99.count_o), (100 - (k % 100)) % 100);
    end
    if99.down_i = 1'b0;

    // Both / neither hold at 42
    do_reset();
    if99.up_i = 1'b1;
    for (int k = 0; k < 42; k++) step();
    check("reach42", int'(if99.count_o), 42);
    if99.down_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("both_hold", int'(if99.count_o), 42);
    end
    {if99.up_i, if99.down_i} = 2'b00;
    for (int k = 0; k < 3; k++) begin
      step();
      check("none_hold", int'(if99.count_o), 42);
    end

    // Reset mid-count with up asserted
    do_reset();
    if99.up_i = 1'b1;
    for (int k = 0; k < 73; k++) step();
    check("reach73", int'(if99.count_o), 73);
    rst = 1'b1;
    step();
    check("mid_reset", int'(if99.count_o), 0);
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      check("resume", int'(if99.count_o), k);
    end
    if99.up_i = 1'b0;

    // Small tables: up then down wraps
    do_reset();
    if7.up_i = 1'b1;
    if1.up_i = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      step();
      check("up7", int'(if7.count_o), k % 8);
      check("up1", int'(if1.count_o), k % 2);
    end
    {if7.up_i, if1.up_i} = 2'b00;
    do_reset();
    if7.down_i = 1'b1;
    if1.down_i = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      check("down7", int'(if7.count_o), (8 - (k % 8)) % 8);
      check("down1", int'(if1.count_o), (2 - (k % 2)) % 2);
    end
    {if7.down_i, if1.down_i} = 2'b00;

    // Random up/down against the reference model
    do_reset();
    m7 = 0;
    m1 = 0;
    for (int k = 0; k < 10000; k++) begin
      {u, d} = 2'($urandom_range(0, 3));
      {if7.up_i, if7.down_i} = {u, d};
      m7 = model_next(m7, u, d, 7);
      {u, d} = 2'($urandom_range(0, 3));
      {if1.up_i, if1.down_i} = {u, d};
      m1 = model_next(m1, u, d, 1);
      step();
      check("rand7", int'(if7.count_o), m7);
      check("rand1", int'(if1.count_o), m1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wave_counter.md
# wave_counter

Modulo up/down counter that generates the sample address for the wavetable oscillators (e.g. the triangle-wave generator). It counts from 0 to a parameterized maximum and wraps in both directions, so a ROM of `max_val_p+1` entries is swept periodically. The output drives a synchronous ROM read address directly; the oscillator's `ready_i` is wired to `up_i`, so the table advances one sample per accepted sample.

## Interface
- `max_val_p`, default 99 (44.1 kHz / 440 Hz → 100-entry table): largest count value; legal range ≥ 1.
- Derived `width_lp` = `$clog2(max_val_p+1)`, minimum 1; equals the consumer's address width `$clog2(depth)`.
- `clk_i`  input  1  sole clock; all state updates on rising edge.
- `reset_i`  input  1  synchronous, active-high reset.
- `up_i`  input  1  advance request: count +1 with wrap.
- `down_i`  input  1  retreat request: count −1 with wrap.
- `count_o`  output  `width_lp`  current count, driven straight from the state register (no combinational path from inputs).

## Operation
- Single register `count_r`, width `width_lp`; `count_o = count_r`.
- Priority per rising edge: reset, then up/down decode.
  - `reset_i=1`: `count_r ← 0`, regardless of `up_i`/`down_i`.
  - `up_i=1, down_i=0`: `count_r ← (count_r == max_val_p) ? 0 : count_r + 1`.
  - `up_i=0, down_i=1`: `count_r ← (count_r == 0) ? max_val_p : count_r − 1`.
  - `up_i=down_i`, both 0 or both 1: hold.
- Wrap compare is against `max_val_p`, not against `2^width_lp − 1`. Values above `max_val_p` are never produced from reset.
- Arithmetic is performed at `width_lp` bits. At `max_val_p = 2^width_lp − 1`, natural overflow and explicit wrap give the same result; the explicit compare is still used.
- No enable, load, or terminal-count outputs; the period is fixed by the parameter.

## Timing
- Reset value: `count_o = 0`, visible the cycle after the reset edge. Reset mid-count discards the count; no wrap event.
- Latency: one cycle from `up_i`/`down_i` sampled at edge N to the new `count_o` after edge N.
- Throughput: one step per cycle with `up_i` held high. The period is exactly `max_val_p+1` cycles (0 … `max_val_p`, 0 …).
- No handshake; inputs are level-sampled every edge and there is no back-pressure.
- Simultaneous up and down is a hold. It is not an error and not a net-zero glitch.
- Downstream ROM data lags `count_o` by one further cycle; that lag is the consumer's concern.

## Structure
- Shared package `wave_pkg`: constants `SAMPLE_FREQ_HZ = 44100.0` and default note frequency 440.0; function `wave_depth(sample_hz, note_hz) = $rtoi(sample_hz/note_hz)`; width helper `clog2_min1(n)`. Oscillators and this counter take widths from these.
- Counter is a single flat module; no sub-module.
- Elaboration-time check: error if `max_val_p < 1`.
- Verification collateral (bench, SVA) lives alongside.
  - SVA: `count_o ≤ max_val_p` always.
  - SVA: one-step delta (mod `max_val_p+1`) when exactly one of up/down is high.
  - SVA: hold otherwise.

## Test plan
- Reset: `max_val_p=99`, random up/down during reset → `count_o=0` each cycle after the reset edge; width is 7.
- Up sweep: hold `up_i=1` for 250 cycles from 0 → sequence 0..99, 0..99, 0..49; wrap 99→0 occurs in a single cycle.
- Down sweep: from reset, `down_i=1` → 99, 98, …, 0, 99; first step 0→99.
- Both/neither: at count 42, apply `up=down=1` for 3 cycles, then 0/0 for 3 cycles → `count_o` stays 42.
- Reset mid-operation: count at 73, assert `reset_i` together with `up_i` → next `count_o=0`; counting resumes 1, 2, … after release.
- Power-of-two boundary: `max_val_p=7` (width 3) and `max_val_p=1` (width 1) → up wraps 7→0 and 1→0; down wraps 0→7 and 0→1; randomized up/down matches the reference model over 10k cycles.
